// File: rtl/pll_lock_seq.sv
// Lock-qualified reset sequencer: filters the PLL lock flag, releases NUM_CH reset domains in a
// staggered order and generates a divided clock enable per domain. Define PLL_LOSS_CNT_EN to build the loss counter.
module pll_lock_seq #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 1024,
    parameter int STAGGER     = 16
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic                    clr_lost,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic [NUM_CH-1:0]       ch_ce,
    output logic                    ready,
    output logic                    lock_lost,
    output logic [7:0]              loss_cnt
);

    localparam int FILT_W = $clog2(LOCK_CYCLES + 1);
    localparam int STG_W  = $clog2(STAGGER + 1);

    typedef enum logic [1:0] {WAIT_LOCK, FILTER, RELEASE, RUN} state_t;

    state_t            state;
    logic [1:0]        sync_q;
    logic              lk;
    logic [FILT_W-1:0] filt_cnt;
    logic [STG_W-1:0]  stg_cnt;
    logic              lost_now;

    // NOTE: every clocked block uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lk       = sync_q[1];
    assign lost_now = !lk && (state == RELEASE || state == RUN);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            filt_cnt  <= '0;
            stg_cnt   <= '0;
            ch_rst_n  <= '0;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            if (lost_now) begin
                lock_lost <= 1'b1;
            end else if (clr_lost) begin
                lock_lost <= 1'b0;
            end

            case (state)
                WAIT_LOCK: begin
                    // The first high lk sample already counts towards the filter length.
                    if (lk) begin
                        state    <= FILTER;
                        filt_cnt <= FILT_W'(1);
                    end else begin
                        filt_cnt <= '0;
                    end
                end
                FILTER: begin
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        filt_cnt <= '0;
                    end else if (filt_cnt == FILT_W'(LOCK_CYCLES - 1)) begin
                        state    <= RELEASE;
                        filt_cnt <= '0;
                        stg_cnt  <= '0;
                        ch_rst_n <= NUM_CH'(1);
                    end else begin
                        filt_cnt <= filt_cnt + FILT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        ch_rst_n <= '0;
                        ready    <= 1'b0;
                    end else if (ch_rst_n[NUM_CH-1]) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else if (stg_cnt == STG_W'(STAGGER - 1)) begin
                        stg_cnt  <= '0;
                        ch_rst_n <= (ch_rst_n << 1) | NUM_CH'(1);
                    end else begin
                        stg_cnt <= stg_cnt + STG_W'(1);
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        ch_rst_n <= '0;
                        ready    <= 1'b0;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

`ifdef PLL_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (lost_now && loss_q != 8'hFF) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_div
        logic [DIV_W-1:0] d_q;
        logic [DIV_W-1:0] cnt_q;

        // While in reset the divide value tracks div_i, so it holds the value seen on the release edge.
        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                d_q   <= '0;
                cnt_q <= '0;
            end else if (!ch_rst_n[i]) begin
                d_q   <= div_i[i*DIV_W +: DIV_W];
                cnt_q <= '0;
            end else if (cnt_q == d_q) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end

        assign ch_ce[i] = ch_rst_n[i] & (cnt_q == d_q);
    end

endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

Parametrised lock-qualified reset sequencer and clock-enable generator that sits directly behind the PLL wrapper in the refclk domain. It synchronises and filters the PLL `locked` flag and releases up to eight downstream reset domains in a staggered order. It generates a programmable-ratio clock enable per domain and tears everything down on loss of lock. Loss-of-lock events are reported through a sticky flag and a saturating counter.

## Interface
- `NUM_CH`, 4: number of reset/enable channels, 1..8
- `DIV_W`, 8: width of each channel divide value
- `LOCK_CYCLES`, 1024: consecutive synchronised-lock cycles required before release, ≥2
- `STAGGER`, 16: cycles between successive channel releases, ≥1

- `refclk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pll_locked`  in  1  raw PLL lock flag, asynchronous to `refclk`
- `div_i`  in  NUM_CH*DIV_W  per-channel divide value D; channel i occupies bits [i*DIV_W +: DIV_W]
- `clr_lost`  in  1  one-cycle pulse that clears `lock_lost`
- `ch_rst_n`  out  NUM_CH  per-channel active-low reset
- `ch_ce`  out  NUM_CH  per-channel clock enable
- `ready`  out  1  all channels released, running
- `lock_lost`  out  1  sticky loss-of-lock flag
- `loss_cnt`  out  8  saturating count of lock losses

## Operation
- Reset values: `ch_rst_n`=0, `ch_ce`=0, `ready`=0, `lock_lost`=0, `loss_cnt`=0, FSM=WAIT_LOCK, synchroniser=0.
- `pll_locked` passes through a 2-flop synchroniser; the FSM uses only the synchronised value `lk`.
- FSM states:
  - WAIT_LOCK: filter counter held at 0; `lk`=1 moves to FILTER.
  - FILTER: counter increments on each `lk`=1 cycle; `lk`=0 returns to WAIT_LOCK without a loss event; after LOCK_CYCLES consecutive high cycles moves to RELEASE.
  - RELEASE: `ch_rst_n[0]` rises on entry; `ch_rst_n[i]` rises STAGGER cycles after `ch_rst_n[i-1]`; one cycle after the last channel release moves to RUN.
  - RUN: `ready`=1.
- In RELEASE or RUN, `lk`=0 returns the FSM to WAIT_LOCK. On the next edge: all `ch_rst_n`=0, all `ch_ce`=0, `ready`=0, `lock_lost`=1, and `loss_cnt` increments (saturates at 255).
- `lock_lost` is cleared by `clr_lost`. A simultaneous new loss event wins over `clr_lost`.
- Divider, per channel:
  - D is latched from `div_i` on the edge the channel's reset releases; later changes to `div_i` are ignored until the next release.
  - Counter is 0 at release, counts 0..D, then wraps to 0.
  - `ch_ce[i]` = `ch_rst_n[i]` & (counter == D).
  - D=0 gives a continuous enable; D gives one pulse every D+1 cycles.
  - Counter is held at 0 while the channel is in reset.
- Reset asserted mid-operation clears all state immediately and asynchronously.

## Timing
- Lock-in latency, with edge 1 the first edge sampling `pll_locked`=1:
  - `ch_rst_n[0]` rises on edge 2+LOCK_CYCLES.
  - `ch_rst_n[i]` rises on edge 2+LOCK_CYCLES+i*STAGGER.
  - `ready` rises one edge after `ch_rst_n[NUM_CH-1]`.
- Lock-loss latency: outputs are deasserted on edge 3 after `pll_locked` falls (2 synchroniser edges plus 1 FSM edge).
- First `ch_ce[i]` pulse occurs D cycles after `ch_rst_n[i]` rises; with D=0 it is in the same cycle.
- A lock glitch shorter than 1 cycle can be missed. Any glitch seen by `lk` restarts filtering from 0.
- All outputs are registered or derived from registers, with no combinational path from inputs.

## Configuration
- `PLL_LOSS_CNT_EN` defined: `loss_cnt` is implemented as described.
- `PLL_LOSS_CNT_EN` undefined: no counter logic is built and `loss_cnt` is tied to 0. `lock_lost` is unaffected.

## Test plan
- NUM_CH=4, LOCK_CYCLES=16, STAGGER=4; raise `pll_locked` -> `ch_rst_n` bits rise on edges 18/22/26/30, `ready` rises on edge 31.
- Drop `pll_locked` for 5 cycles during FILTER at count 10 -> filter restarts; `ch_rst_n[0]` rises 16 cycles after `lk` returns high; `lock_lost`=0.
- `div_i` for ch1 = 3, ch2 = 0 -> ch1 enable pulses every 4 cycles starting 3 cycles after release; ch2 enable is continuously high after release.
- Drop `pll_locked` in RUN -> all outputs 0 on edge 3, `lock_lost`=1, `loss_cnt`=1; re-lock sequences again; `clr_lost` pulse -> `lock_lost`=0.
- Force 300 loss events -> `loss_cnt` holds at 255; with macro undefined, `loss_cnt` stays 0.
- Assert `rst_n` during RELEASE after ch1 is released -> all outputs 0 immediately; FSM in WAIT_LOCK after reset is released.
